// File: rtl/tlb_unit.sv
// rtl/tlb_unit.sv - 32-entry fully associative MIPS32 joint TLB
// Array, TLBR/TLBP/TLBW access and one registered translation port.
module tlb_unit #(
   parameter int TLB_ENTRIES = 32,
   parameter int IDX_BITS    = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                tlbw,
   input  logic                tlbr,
   input  logic                tlbp,
   input  logic [IDX_BITS-1:0] cp0_index,
   input  logic [31:0]         EntryHi_i,
   input  logic [31:0]         EntryLo0_i,
   input  logic [31:0]         EntryLo1_i,
   input  logic [11:0]         PageMask_i,
   output logic [31:0]         EntryHi_o,
   output logic [31:0]         EntryLo0_o,
   output logic [31:0]         EntryLo1_o,
   output logic [11:0]         PageMask_o,
   output logic [31:0]         Index_o,
   input  logic                lk_req,
   input  logic [31:0]         lk_vaddr,
   input  logic                lk_store,
   input  logic                cp0_erl,
   input  logic                cp0_kseg0_cached,
   output logic                rsp_valid,
   output logic [31:0]         rsp_paddr,
   output logic                rsp_cached,
   output logic                rsp_refill,
   output logic                rsp_invalid,
   output logic                rsp_modified
);

   logic [18:0] vpn2_q [TLB_ENTRIES];
   logic [7:0]  asid_q [TLB_ENTRIES];
   logic        g_q    [TLB_ENTRIES];
   logic [11:0] mask_q [TLB_ENTRIES];
   logic [19:0] pfn0_q [TLB_ENTRIES];
   logic [2:0]  c0_q   [TLB_ENTRIES];
   logic        d0_q   [TLB_ENTRIES];
   logic        v0_q   [TLB_ENTRIES];
   logic [19:0] pfn1_q [TLB_ENTRIES];
   logic [2:0]  c1_q   [TLB_ENTRIES];
   logic        d1_q   [TLB_ENTRIES];
   logic        v1_q   [TLB_ENTRIES];

   logic unused_bits;
   assign unused_bits = tlbr ^ tlbp ^ (^EntryHi_i[12:8]) ^ (^EntryLo0_i[31:26]) ^ (^EntryLo1_i[31:26]);

   function automatic logic [3:0] popcnt12(input logic [11:0] m);
      logic [3:0] n;
      n = 4'd0;
      for (int b = 0; b < 12; b++) n = n + {3'b0, m[b]};
      return n;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < TLB_ENTRIES; i++) begin
            vpn2_q[i] <= '0; asid_q[i] <= '0; g_q[i]  <= 1'b0; mask_q[i] <= '0;
            pfn0_q[i] <= '0; c0_q[i]   <= '0; d0_q[i] <= 1'b0; v0_q[i]   <= 1'b0;
            pfn1_q[i] <= '0; c1_q[i]   <= '0; d1_q[i] <= 1'b0; v1_q[i]   <= 1'b0;
         end
      end else if (tlbw) begin
         vpn2_q[cp0_index] <= EntryHi_i[31:13] & ~{7'b0, PageMask_i};
         asid_q[cp0_index] <= EntryHi_i[7:0];
         g_q[cp0_index]    <= EntryLo0_i[0] & EntryLo1_i[0];
         mask_q[cp0_index] <= PageMask_i;
         pfn0_q[cp0_index] <= EntryLo0_i[25:6];
         c0_q[cp0_index]   <= EntryLo0_i[5:3];
         d0_q[cp0_index]   <= EntryLo0_i[2];
         v0_q[cp0_index]   <= EntryLo0_i[1];
         pfn1_q[cp0_index] <= EntryLo1_i[25:6];
         c1_q[cp0_index]   <= EntryLo1_i[5:3];
         d1_q[cp0_index]   <= EntryLo1_i[2];
         v1_q[cp0_index]   <= EntryLo1_i[1];
      end
   end

   always_comb begin
      EntryHi_o  = {vpn2_q[cp0_index], 5'b0, asid_q[cp0_index]};
      EntryLo0_o = {6'b0, pfn0_q[cp0_index], c0_q[cp0_index], d0_q[cp0_index],
                    v0_q[cp0_index], g_q[cp0_index]};
      EntryLo1_o = {6'b0, pfn1_q[cp0_index], c1_q[cp0_index], d1_q[cp0_index],
                    v1_q[cp0_index], g_q[cp0_index]};
      PageMask_o = mask_q[cp0_index];
   end

   // Both searches scan downward so the lowest matching index wins.
   logic                pr_hit, lk_hit;
   logic [IDX_BITS-1:0] pr_idx, lk_idx;

   always_comb begin
      pr_hit = 1'b0;
      pr_idx = '0;
      lk_hit = 1'b0;
      lk_idx = '0;
      for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
         if ((((EntryHi_i[31:13] ^ vpn2_q[i]) & ~{7'b0, mask_q[i]}) == 19'd0) &&
             (g_q[i] || asid_q[i] == EntryHi_i[7:0])) begin
            pr_hit = 1'b1;
            pr_idx = i[IDX_BITS-1:0];
         end
         if ((((lk_vaddr[31:13] ^ vpn2_q[i]) & ~{7'b0, mask_q[i]}) == 19'd0) &&
             (g_q[i] || asid_q[i] == EntryHi_i[7:0])) begin
            lk_hit = 1'b1;
            lk_idx = i[IDX_BITS-1:0];
         end
      end
   end

   assign Index_o = {~pr_hit, {(31 - IDX_BITS){1'b0}}, pr_idx};

   logic [4:0]  sel_bit;
   logic        odd;
   logic [19:0] s_pfn;
   logic [2:0]  s_c;
   logic        s_d, s_v;
   logic [31:0] pm;
   logic [31:0] nxt_paddr;
   logic        nxt_cached, nxt_refill, nxt_invalid, nxt_modified;

   always_comb begin
      sel_bit      = 5'd12 + {1'b0, popcnt12(mask_q[lk_idx])};
      odd          = lk_vaddr[sel_bit];
      s_pfn        = odd ? pfn1_q[lk_idx] : pfn0_q[lk_idx];
      s_c          = odd ? c1_q[lk_idx]   : c0_q[lk_idx];
      s_d          = odd ? d1_q[lk_idx]   : d0_q[lk_idx];
      s_v          = odd ? v1_q[lk_idx]   : v0_q[lk_idx];
      pm           = {8'b0, mask_q[lk_idx], 12'hFFF};
      nxt_paddr    = 32'd0;
      nxt_cached   = 1'b0;
      nxt_refill   = 1'b0;
      nxt_invalid  = 1'b0;
      nxt_modified = 1'b0;
      if (lk_vaddr[31:29] == 3'b100) begin
         nxt_paddr  = {3'b0, lk_vaddr[28:0]};
         nxt_cached = cp0_kseg0_cached;
      end else if (lk_vaddr[31:29] == 3'b101) begin
         nxt_paddr = {3'b0, lk_vaddr[28:0]};
      end else if (!lk_vaddr[31] && cp0_erl) begin
         nxt_paddr = lk_vaddr;
      end else if (!lk_hit) begin
         nxt_refill = 1'b1;
      end else if (!s_v) begin
         nxt_invalid = 1'b1;
      end else if (lk_store && !s_d) begin
         nxt_modified = 1'b1;
      end else begin
         nxt_paddr  = ({s_pfn, 12'b0} & ~pm) | (lk_vaddr & pm);
         nxt_cached = (s_c == 3'd3);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid    <= 1'b0;
         rsp_paddr    <= 32'd0;
         rsp_cached   <= 1'b0;
         rsp_refill   <= 1'b0;
         rsp_invalid  <= 1'b0;
         rsp_modified <= 1'b0;
      end else begin
         rsp_valid    <= lk_req;
         rsp_paddr    <= lk_req ? nxt_paddr : 32'd0;
         rsp_cached   <= lk_req & nxt_cached;
         rsp_refill   <= lk_req & nxt_refill;
         rsp_invalid  <= lk_req & nxt_invalid;
         rsp_modified <= lk_req & nxt_modified;
      end
   end

endmodule

// File: tb/tb_tlb_unit.sv
// tb/tb_tlb_unit.sv - self-checking bench for tlb_unit
// Expected translation results are queued at issue and popped at the response.
module tb_tlb_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        tlbw, tlbr, tlbp;
   logic [4:0]  cp0_index;
   logic [31:0] EntryHi_i, EntryLo0_i, EntryLo1_i;
   logic [11:0] PageMask_i;
   logic [31:0] EntryHi_o, EntryLo0_o, EntryLo1_o, Index_o;
   logic [11:0] PageMask_o;
   logic        lk_req, lk_store, cp0_erl, cp0_kseg0_cached;
   logic [31:0] lk_vaddr;
   logic        rsp_valid, rsp_cached, rsp_refill, rsp_invalid, rsp_modified;
   logic [31:0] rsp_paddr;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [31:0] paddr;
      logic        cached;
      logic        refill;
      logic        invalid;
      logic        modified;
   } exp_t;

   exp_t exp_q[$];

   tlb_unit #(.TLB_ENTRIES(32), .IDX_BITS(5)) dut (
      .clk(clk), .reset(reset), .tlbw(tlbw), .tlbr(tlbr), .tlbp(tlbp),
      .cp0_index(cp0_index), .EntryHi_i(EntryHi_i), .EntryLo0_i(EntryLo0_i),
      .EntryLo1_i(EntryLo1_i), .PageMask_i(PageMask_i), .EntryHi_o(EntryHi_o),
      .EntryLo0_o(EntryLo0_o), .EntryLo1_o(EntryLo1_o), .PageMask_o(PageMask_o),
      .Index_o(Index_o), .lk_req(lk_req), .lk_vaddr(lk_vaddr), .lk_store(lk_store),
      .cp0_erl(cp0_erl), .cp0_kseg0_cached(cp0_kseg0_cached), .rsp_valid(rsp_valid),
      .rsp_paddr(rsp_paddr), .rsp_cached(rsp_cached), .rsp_refill(rsp_refill),
      .rsp_invalid(rsp_invalid), .rsp_modified(rsp_modified)
   );

   always #5 clk = ~clk;

   task automatic tlb_write(input logic [4:0] idx, input logic [31:0] hi, lo0, lo1,
                            input logic [11:0] pm);
      tlbw = 1'b1; cp0_index = idx; EntryHi_i = hi;
      EntryLo0_i = lo0; EntryLo1_i = lo1; PageMask_i = pm;
      @(posedge clk); #1;
      tlbw = 1'b0;
   endtask

   // Caller sets EntryHi_i (ASID), cp0_erl and cp0_kseg0_cached beforehand.
   task automatic lookup(input string name, input logic [31:0] va, input logic st,
                         input logic [31:0] paddr, input logic cached, refill, invalid, modified);
      exp_t e;
      e = '{paddr: paddr, cached: cached, refill: refill, invalid: invalid, modified: modified};
      exp_q.push_back(e);
      lk_req = 1'b1; lk_vaddr = va; lk_store = st;
      @(posedge clk); #1;
      lk_req = 1'b0; lk_store = 1'b0;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++; $display("FAIL %s scoreboard empty", name);
      end else begin
         e = exp_q.pop_front();
         if (rsp_valid !== 1'b1) begin
            n_fail++; $display("FAIL %s rsp_valid got %0b exp 1", name, rsp_valid);
         end
         n_checks++;
         if (rsp_refill !== e.refill || rsp_invalid !== e.invalid || rsp_modified !== e.modified) begin
            n_fail++;
            $display("FAIL %s faults got r%0b i%0b m%0b exp r%0b i%0b m%0b", name,
                     rsp_refill, rsp_invalid, rsp_modified, e.refill, e.invalid, e.modified);
         end
         n_checks++;
         if (rsp_cached !== e.cached) begin
            n_fail++; $display("FAIL %s rsp_cached got %0b exp %0b", name, rsp_cached, e.cached);
         end
         if (!(e.refill || e.invalid || e.modified)) begin
            n_checks++;
            if (rsp_paddr !== e.paddr) begin
               n_fail++; $display("FAIL %s rsp_paddr got %h exp %h", name, rsp_paddr, e.paddr);
            end
         end
      end
   endtask

   task automatic test_reset;
      n_checks++;
      if (rsp_valid !== 1'b0 || rsp_paddr !== 32'd0 || rsp_refill !== 1'b0) begin
         n_fail++; $display("FAIL reset_rsp got v%0b pa %h r%0b exp 0", rsp_valid, rsp_paddr, rsp_refill);
      end
      tlbr = 1'b1; cp0_index = 5'd3; #1;
      n_checks++;
      if (EntryHi_o !== 32'd0 || EntryLo0_o !== 32'd0 || EntryLo1_o !== 32'd0 || PageMask_o !== 12'd0) begin
         n_fail++; $display("FAIL reset_tlbr got %h %h %h %h exp 0", EntryHi_o, EntryLo0_o, EntryLo1_o, PageMask_o);
      end
      tlbr = 1'b0;
      EntryHi_i = 32'h0040_0000;
      lookup("reset_refill", 32'h0040_0000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      tlbp = 1'b1; EntryHi_i = 32'h0040_0000; #1;
      n_checks++;
      if (Index_o !== 32'h8000_0000) begin
         n_fail++; $display("FAIL reset_tlbp Index_o got %h exp 80000000", Index_o);
      end
      tlbp = 1'b0;
   endtask

   task automatic test_write_read;
      tlb_write(5'd3, 32'h0040_0005, 32'h0000_105F, 32'h0000_1087, 12'h000);
      tlbr = 1'b1; cp0_index = 5'd3; #1;
      n_checks++;
      if (EntryHi_o !== 32'h0040_0005 || EntryLo0_o !== 32'h0000_105F ||
          EntryLo1_o !== 32'h0000_1087 || PageMask_o !== 12'h000) begin
         n_fail++;
         $display("FAIL tlbr_idx3 got %h %h %h %h exp 00400005 0000105f 00001087 000",
                  EntryHi_o, EntryLo0_o, EntryLo1_o, PageMask_o);
      end
      tlbr = 1'b0;
      EntryHi_i = 32'h0000_0000;
      lookup("even_page", 32'h0040_0ABC, 1'b0, 32'h0004_1ABC, 1'b1, 1'b0, 1'b0, 1'b0);
      lookup("odd_page", 32'h0040_1010, 1'b0, 32'h0004_2010, 1'b0, 1'b0, 1'b0, 1'b0);
      lookup("odd_store", 32'h0040_1010, 1'b1, 32'h0004_2010, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_large_page;
      tlb_write(5'd5, 32'h0100_0000, 32'h0000_401D, 32'h0000_411B, 12'h003);
      EntryHi_i = 32'h0000_0000;
      lookup("16k_invalid", 32'h0100_2000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      lookup("16k_modified", 32'h0100_4000, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      lookup("16k_load", 32'h0100_4567, 1'b0, 32'h0010_4567, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_asid;
      tlb_write(5'd7, 32'h0200_0012, 32'h0000_1046, 32'h0000_1086, 12'h000);
      EntryHi_i = 32'h0000_0013;
      lookup("asid_miss", 32'h0200_0100, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      EntryHi_i = 32'h0000_0012;
      lookup("asid_hit", 32'h0200_0100, 1'b0, 32'h0004_1100, 1'b0, 1'b0, 1'b0, 1'b0);
      tlbp = 1'b1; EntryHi_i = 32'h0200_0012; #1;
      n_checks++;
      if (Index_o !== 32'h0000_0007) begin
         n_fail++; $display("FAIL tlbp_idx7 Index_o got %h exp 00000007", Index_o);
      end
      tlbp = 1'b0;
   endtask

   task automatic test_unmapped;
      EntryHi_i = 32'h0000_0000;
      cp0_kseg0_cached = 1'b1;
      lookup("kseg0", 32'h8000_1234, 1'b0, 32'h0000_1234, 1'b1, 1'b0, 1'b0, 1'b0);
      lookup("kseg1", 32'hA000_1234, 1'b1, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 1'b0);
      cp0_kseg0_cached = 1'b0;
      cp0_erl = 1'b1;
      lookup("erl_kuseg", 32'h0000_1000, 1'b0, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 1'b0);
      cp0_erl = 1'b0;
   endtask

   task automatic test_back_to_back;
      // Write and lookup in the same cycle: the lookup must see the old (empty) entry.
      tlbw = 1'b1; cp0_index = 5'd10; EntryHi_i = 32'h0300_0000;
      EntryLo0_i = 32'h0000_1047; EntryLo1_i = 32'h0000_1047; PageMask_i = 12'h000;
      lookup("same_cycle_old", 32'h0300_0123, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      tlbw = 1'b0;
      lookup("next_cycle_new", 32'h0300_0123, 1'b0, 32'h0004_1123, 1'b0, 1'b0, 1'b0, 1'b0);
      tlb_write(5'd12, 32'h0300_0000, 32'h0000_1547, 32'h0000_1547, 12'h000);
      EntryHi_i = 32'h0300_0000;
      lookup("lowest_wins", 32'h0300_0123, 1'b0, 32'h0004_1123, 1'b0, 1'b0, 1'b0, 1'b0);
      tlbp = 1'b1; #1;
      n_checks++;
      if (Index_o !== 32'h0000_000A) begin
         n_fail++; $display("FAIL tlbp_lowest Index_o got %h exp 0000000a", Index_o);
      end
      tlbp = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL idle_valid got %0b exp 0", rsp_valid);
      end
   endtask

   task automatic test_reset_inflight;
      lk_req = 1'b1; lk_vaddr = 32'h8000_0000; reset = 1'b1;
      @(posedge clk); #1;
      lk_req = 1'b0; reset = 1'b0;
      n_checks++;
      if (rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_drop rsp_valid got %0b exp 0", rsp_valid);
      end
      tlbr = 1'b1; cp0_index = 5'd3; #1;
      n_checks++;
      if (EntryHi_o !== 32'd0 || EntryLo0_o !== 32'd0) begin
         n_fail++; $display("FAIL reset_clear got %h %h exp 0", EntryHi_o, EntryLo0_o);
      end
      tlbr = 1'b0;
   endtask

   initial begin
      reset = 1'b1; tlbw = 1'b0; tlbr = 1'b0; tlbp = 1'b0; cp0_index = '0;
      EntryHi_i = '0; EntryLo0_i = '0; EntryLo1_i = '0; PageMask_i = '0;
      lk_req = 1'b0; lk_vaddr = '0; lk_store = 1'b0; cp0_erl = 1'b0; cp0_kseg0_cached = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      test_reset();
      test_write_read();
      test_large_page();
      test_asid();
      test_unmapped();
      test_back_to_back();
      test_reset_inflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
